dynamic_branch_predictor: RTL and testbench

DYNAMIC_BRANCH_PREDICTOR -- requirements
Module: dynamic_branch_predictor

---
 rtl/bp_pkg.sv | 24 ++
 rtl/bp_sat_counter.sv | 27 ++
 rtl/dynamic_branch_predictor.sv | 131 +++++++++++++
 tb/tb_dynamic_branch_predictor.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and defaults for the dynamic branch predictor.
package bp_pkg;

  // 2-bit saturating counter states
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_state_e;

  localparam int unsigned DEFAULT_PC_WIDTH   = 16;
  localparam int unsigned DEFAULT_INDEX_BITS = 4;

  // Tag covers PC bits above the index; PC[0] is never used.
  function automatic int unsigned tag_width(input int unsigned pc_w,
                                            input int unsigned idx_b);
    return pc_w - idx_b - 1;
  endfunction

  localparam int unsigned DEFAULT_TAG_WIDTH =
    tag_width(DEFAULT_PC_WIDTH, DEFAULT_INDEX_BITS);

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating counter next-state logic.
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] state_i,
  input  logic       taken_i,
  output logic [1:0] state_o
);

  ctr_state_e cur;
  ctr_state_e nxt;

  // Step toward ST on taken, toward SNT on not-taken, holding at the ends
  always_comb begin
    cur = ctr_state_e'(state_i);
    nxt = cur;
    unique case (cur)
      SNT: nxt = taken_i ? WNT : SNT;
      WNT: nxt = taken_i ? WT  : SNT;
      WT:  nxt = taken_i ? ST  : WNT;
      ST:  nxt = taken_i ? ST  : WT;
      default: nxt = WNT;
    endcase
    state_o = nxt;
  end

endmodule

// File: rtl/dynamic_branch_predictor.sv
// Direct-mapped, tagged 2-bit-counter branch predictor with target storage,
// decode-stage resolution and a saturating mispredict counter.
module dynamic_branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned PC_WIDTH   = DEFAULT_PC_WIDTH,
  parameter int unsigned INDEX_BITS = DEFAULT_INDEX_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] IF_PC,
  input  logic [PC_WIDTH-1:0] ID_PC,
  input  logic                ID_is_branch,
  input  logic                ID_pred_taken,
  input  logic [PC_WIDTH-1:0] ID_pred_target,
  input  logic                actual_taken,
  input  logic [PC_WIDTH-1:0] actual_target,
  input  logic                update_en,
  output logic                pred_taken,
  output logic [PC_WIDTH-1:0] pred_target,
  output logic                branch_mispredicted,
  output logic                branch_taken,
  output logic [PC_WIDTH-1:0] recovery_PC,
  output logic [15:0]         mispredict_count
);

  localparam int unsigned TAG_W   = tag_width(PC_WIDTH, INDEX_BITS);
  localparam int unsigned ENTRIES = 2 ** INDEX_BITS;
  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(2);

  logic                valid_q  [ENTRIES];
  logic                valid_d  [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [TAG_W-1:0]    tag_d    [ENTRIES];
  ctr_state_e          ctr_q    [ENTRIES];
  ctr_state_e          ctr_d    [ENTRIES];
  logic [PC_WIDTH-1:0] target_q [ENTRIES];
  logic [PC_WIDTH-1:0] target_d [ENTRIES];
  logic [15:0]         count_q;
  logic [15:0]         count_d;

  logic [INDEX_BITS-1:0] if_idx;
  logic [TAG_W-1:0]      if_tag;
  logic                  if_hit;
  logic [INDEX_BITS-1:0] id_idx;
  logic [TAG_W-1:0]      id_tag;
  logic                  id_hit;
  logic                  do_update;
  logic [1:0]            ctr_stepped;
  logic                  unused_pc_lsb;

  assign unused_pc_lsb = IF_PC[0] ^ ID_PC[0];

  // Fetch-stage lookup; reads registered state only, so no same-cycle bypass
  always_comb begin
    if_idx      = IF_PC[INDEX_BITS:1];
    if_tag      = IF_PC[PC_WIDTH-1:INDEX_BITS+1];
    if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_taken  = if_hit && ctr_q[if_idx][1];
    pred_target = if_hit ? target_q[if_idx] : '0;
  end

  // Decode-stage resolution outputs
  always_comb begin
    branch_taken        = ID_is_branch && actual_taken;
    branch_mispredicted = ID_is_branch &&
                          ((ID_pred_taken != actual_taken) ||
                           (actual_taken && (ID_pred_target != actual_target)));
    recovery_PC         = actual_taken ? actual_target : (ID_PC + PC_STEP);
    mispredict_count    = count_q;
  end

  bp_sat_counter u_sat_counter (
    .state_i (ctr_q[id_idx]),
    .taken_i (actual_taken),
    .state_o (ctr_stepped)
  );

  // Table update: train on a hit, allocate on a miss
  always_comb begin
    id_idx    = ID_PC[INDEX_BITS:1];
    id_tag    = ID_PC[PC_WIDTH-1:INDEX_BITS+1];
    id_hit    = valid_q[id_idx] && (tag_q[id_idx] == id_tag);
    do_update = ID_is_branch && update_en;
    valid_d   = valid_q;
    tag_d     = tag_q;
    ctr_d     = ctr_q;
    target_d  = target_q;
    if (do_update) begin
      if (id_hit) begin
        ctr_d[id_idx] = ctr_state_e'(ctr_stepped);
        if (actual_taken) begin
          target_d[id_idx] = actual_target;
        end
      end else begin
        valid_d[id_idx]  = 1'b1;
        tag_d[id_idx]    = id_tag;
        ctr_d[id_idx]    = actual_taken ? WT : WNT;
        target_d[id_idx] = actual_target;
      end
    end
  end

  // Count committed mispredictions, saturating at all-ones
  always_comb begin
    count_d = count_q;
    if (do_update && branch_mispredicted && (count_q != '1)) begin
      count_d = count_q + 16'd1;
    end
  end

  // Table and counter state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        ctr_q[i]    <= WNT;
        target_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      ctr_q    <= ctr_d;
      target_q <= target_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_dynamic_branch_predictor.sv
// Self-checking bench for dynamic_branch_predictor (default parameters).
module tb_dynamic_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] IF_PC = '0;
  logic [15:0] ID_PC = '0;
  logic        ID_is_branch = 1'b0;
  logic        ID_pred_taken = 1'b0;
  logic [15:0] ID_pred_target = '0;
  logic        actual_taken = 1'b0;
  logic [15:0] actual_target = '0;
  logic        update_en = 1'b0;
  logic        pred_taken;
  logic [15:0] pred_target;
  logic        branch_mispredicted;
  logic        branch_taken;
  logic [15:0] recovery_PC;
  logic [15:0] mispredict_count;

  int checks = 0;
  int errors = 0;

  dynamic_branch_predictor #(.PC_WIDTH(16), .INDEX_BITS(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .IF_PC               (IF_PC),
    .ID_PC               (ID_PC),
    .ID_is_branch        (ID_is_branch),
    .ID_pred_taken       (ID_pred_taken),
    .ID_pred_target      (ID_pred_target),
    .actual_taken        (actual_taken),
    .actual_target       (actual_target),
    .update_en           (update_en),
    .pred_taken          (pred_taken),
    .pred_target         (pred_target),
    .branch_mispredicted (branch_mispredicted),
    .branch_taken        (branch_taken),
    .recovery_PC         (recovery_PC),
    .mispredict_count    (mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each slot remembers the full PC that owns it; strength is 0..3.
  bit m_valid [16];
  int m_pc    [16];
  int m_str   [16];
  int m_tgt   [16];
  int m_count;

  function automatic int slot(input int pc);
    return (pc / 2) % 16;
  endfunction

  function automatic bit owns(input int pc);
    return m_valid[slot(pc)] && ((m_pc[slot(pc)] / 32) == (pc / 32));
  endfunction

  function automatic bit exp_mispred();
    if (!ID_is_branch) return 1'b0;
    if (ID_pred_taken != actual_taken) return 1'b1;
    return actual_taken && (ID_pred_target != actual_target);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 1'b0;
        m_pc[i]    = 0;
        m_str[i]   = 1;
        m_tgt[i]   = 0;
      end
      m_count = 0;
    end else if (ID_is_branch && update_en) begin
      int s;
      s = slot(int'(ID_PC));
      if (exp_mispred() && m_count < 65535) m_count = m_count + 1;
      if (owns(int'(ID_PC))) begin
        if (actual_taken) begin
          m_str[s] = (m_str[s] == 3) ? 3 : m_str[s] + 1;
          m_tgt[s] = int'(actual_target);
        end else begin
          m_str[s] = (m_str[s] == 0) ? 0 : m_str[s] - 1;
        end
      end else begin
        m_valid[s] = 1'b1;
        m_pc[s]    = int'(ID_PC);
        m_str[s]   = actual_taken ? 2 : 1;
        m_tgt[s]   = int'(actual_target);
      end
    end
  end

  // Compare every output against the model away from the clock edge
  always @(negedge clk) begin
    int s;
    bit h;
    s = slot(int'(IF_PC));
    h = owns(int'(IF_PC));
    chk("m_pred_taken", 32'(pred_taken), 32'(h && m_str[s] >= 2));
    chk("m_pred_target", 32'(pred_target), h ? 32'(m_tgt[s]) : 32'd0);
    chk("m_mispred", 32'(branch_mispredicted), 32'(exp_mispred()));
    chk("m_br_taken", 32'(branch_taken), 32'(ID_is_branch && actual_taken));
    chk("m_recovery", 32'(recovery_PC),
        actual_taken ? 32'(actual_target) : 32'((int'(ID_PC) + 2) % 65536));
    chk("m_count", 32'(mispredict_count), 32'(m_count));
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic br(input logic [15:0] pc, input logic pt, input logic [15:0] ptgt,
                    input logic at, input logic [15:0] atgt, input logic en);
    ID_PC = pc; ID_is_branch = 1'b1; ID_pred_taken = pt; ID_pred_target = ptgt;
    actual_taken = at; actual_target = atgt; update_en = en;
  endtask

  task automatic idle();
    ID_is_branch = 1'b0; update_en = 1'b1; ID_pred_taken = 1'b0; actual_taken = 1'b0;
  endtask

  initial begin
    #100_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    tick(); tick();
    rst = 1'b0;
    // Reset state lookup
    IF_PC = 16'h0010; #1;
    chk("rst_pred_taken", 32'(pred_taken), 32'd0);
    chk("rst_pred_target", 32'(pred_target), 32'h0);
    chk("rst_count", 32'(mispredict_count), 32'd0);

    // First taken update allocates WT
    br(16'h0010, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b1); #1;
    chk("alloc_mispred", 32'(branch_mispredicted), 32'd1);
    chk("alloc_taken", 32'(branch_taken), 32'd1);
    chk("alloc_recovery", 32'(recovery_PC), 32'h0040);
    chk("no_bypass", 32'(pred_taken), 32'd0);
    tick(); idle(); #1;
    chk("alloc_count", 32'(mispredict_count), 32'd1);
    chk("alloc_pred_taken", 32'(pred_taken), 32'd1);
    chk("alloc_pred_target", 32'(pred_target), 32'h0040);

    // WT -> ST -> ST -> ST -> WT -> WNT
    for (int i = 0; i < 3; i++) begin
      br(16'h0010, 1'b1, 16'h0040, 1'b1, 16'h0040, 1'b1); tick();
    end
    br(16'h0010, 1'b1, 16'h0040, 1'b0, 16'h0040, 1'b1); tick();
    idle(); #1;
    chk("wt_pred_taken", 32'(pred_taken), 32'd1);
    br(16'h0010, 1'b1, 16'h0040, 1'b0, 16'h0040, 1'b1); tick();
    idle(); #1;
    chk("wnt_pred_taken", 32'(pred_taken), 32'd0);
    chk("wnt_pred_target", 32'(pred_target), 32'h0040);
    chk("wnt_count", 32'(mispredict_count), 32'd3);

    // Alias: 0x0030 shares index with 0x0010
    br(16'h0030, 1'b0, 16'h0000, 1'b0, 16'h0050, 1'b1); tick();
    idle(); #1;
    chk("alias_old_taken", 32'(pred_taken), 32'd0);
    chk("alias_old_target", 32'(pred_target), 32'h0);
    IF_PC = 16'h0030; #1;
    chk("alias_new_target", 32'(pred_target), 32'h0050);

    // Stalled mispredict counted once
    IF_PC = 16'h0020;
    br(16'h0020, 1'b0, 16'h0000, 1'b1, 16'h0060, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_count", 32'(mispredict_count), 32'd3);
      chk("stall_pred_taken", 32'(pred_taken), 32'd0);
    end
    update_en = 1'b1; tick(); idle(); #1;
    chk("release_count", 32'(mispredict_count), 32'd4);
    chk("release_pred_target", 32'(pred_target), 32'h0060);

    // Not-taken mispredict at top of PC space wraps
    br(16'hFFFE, 1'b1, 16'h1234, 1'b0, 16'h1234, 1'b1); #1;
    chk("wrap_recovery", 32'(recovery_PC), 32'h0000);
    chk("wrap_mispred", 32'(branch_mispredicted), 32'd1);
    tick(); idle(); #1;
    chk("wrap_count", 32'(mispredict_count), 32'd5);

    // Reset in the middle of an update cycle
    IF_PC = 16'h0030;
    br(16'h0010, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b1);
    rst = 1'b1; #1;
    chk("midrst_target", 32'(pred_target), 32'h0);
    chk("midrst_count", 32'(mispredict_count), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    IF_PC = 16'h0010; #1;
    chk("post_rst_update_count", 32'(mispredict_count), 32'd1);
    chk("post_rst_update_pred", 32'(pred_taken), 32'd1);

    // Drive the count up to saturation, then one more
    br(16'h0010, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b1);
    for (int i = 0; i < 65534; i++) tick();
    chk("sat_count", 32'(mispredict_count), 32'hFFFF);
    tick();
    chk("sat_hold", 32'(mispredict_count), 32'hFFFF);
    idle(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
